// File: rtl/proc_control_fsm.sv
// proc_control_fsm
//   Control unit for the 16-bit bus processor. Holds the 9-bit instruction
//   register and steps one instruction through T0..T3 per Run request,
//   selecting exactly one bus source per cycle and raising the register,
//   A and G load enables.
//   Instruction format: IR[8:6]=opcode, IR[5:3]=X (dest), IR[2:0]=Y (src).
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset (forces all outputs low)
//   run_i       start request, only looked at in T0
//   din_ir_i    instruction bits, captured into IR when ir_in_o=1
//   ir_in_o     IR load enable (T0 & Run)
//   r_out_o     one-hot bus-source select, bit7=R0 ... bit0=R7
//   g_out_o     G drives the bus
//   din_out_o   DIN drives the bus
//   r_in_o      one-hot register write enable, bit7=R0 ... bit0=R7
//   a_in_o      load A from the bus
//   g_in_o      load G from the ALU
//   add_sub_o   ALU op: 0 = A+bus, 1 = A-bus
//   done_o      last step of the current instruction
module proc_control_fsm #(
  parameter int IR_W = 9,  // only 9 is supported
  parameter int NREG = 8   // only 8 is supported
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [IR_W-1:0] din_ir_i,
  output logic            ir_in_o,
  output logic [NREG-1:0] r_out_o,
  output logic            g_out_o,
  output logic            din_out_o,
  output logic [NREG-1:0] r_in_o,
  output logic            a_in_o,
  output logic            g_in_o,
  output logic            add_sub_o,
  output logic            done_o
);

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_t           step_q, step_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0]      opcode;
  logic [2:0]      x_idx;
  logic [2:0]      y_idx;
  logic [NREG-1:0] x_oh;
  logic [NREG-1:0] y_oh;

  assign opcode = ir_q[8:6];
  assign x_idx  = ir_q[5:3];
  assign y_idx  = ir_q[2:0];

  // Register n maps to bit (NREG-1-n), so R0 lands on the MSB.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    assign x_oh[gi] = (x_idx == 3'(NREG - 1 - gi));
    assign y_oh[gi] = (y_idx == 3'(NREG - 1 - gi));
  end

  always_comb begin
    step_d    = step_q;
    ir_d      = ir_q;
    ir_in_o   = 1'b0;
    r_out_o   = '0;
    g_out_o   = 1'b0;
    din_out_o = 1'b0;
    r_in_o    = '0;
    a_in_o    = 1'b0;
    g_in_o    = 1'b0;
    add_sub_o = 1'b0;
    done_o    = 1'b0;

    unique case (step_q)
      T0: begin
        ir_in_o = run_i;
        if (run_i) begin
          ir_d   = din_ir_i;
          step_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            r_out_o = y_oh;
            r_in_o  = x_oh;
            done_o  = 1'b1;
            step_d  = T0;
          end
          OP_MVI: begin
            din_out_o = 1'b1;
            r_in_o    = x_oh;
            done_o    = 1'b1;
            step_d    = T0;
          end
          OP_ADD, OP_SUB: begin
            r_out_o = x_oh;
            a_in_o  = 1'b1;
            step_d  = T2;
          end
          default: begin
            // Opcodes 100..111 retire as NOPs.
            done_o = 1'b1;
            step_d = T0;
          end
        endcase
      end
      T2: begin
        r_out_o   = y_oh;
        g_in_o    = 1'b1;
        add_sub_o = opcode[0];
        step_d    = T3;
      end
      T3: begin
        g_out_o = 1'b1;
        r_in_o  = x_oh;
        done_o  = 1'b1;
        step_d  = T0;
      end
      default: step_d = T0;
    endcase

    // Outputs are decoded from Run as well as state, so reset must gate
    // them directly: IRin would otherwise follow Run while in reset.
    if (rst_i) begin
      ir_in_o   = 1'b0;
      r_out_o   = '0;
      g_out_o   = 1'b0;
      din_out_o = 1'b0;
      r_in_o    = '0;
      a_in_o    = 1'b0;
      g_in_o    = 1'b0;
      add_sub_o = 1'b0;
      done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
module tb_proc_control_fsm;

  logic       clk;
  logic       rst;
  logic       run;
  logic [8:0] din;
  logic       ir_in;
  logic [7:0] r_out;
  logic       g_out;
  logic       din_out;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       add_sub;
  logic       done;

  proc_control_fsm dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .din_ir_i  (din),
    .ir_in_o   (ir_in),
    .r_out_o   (r_out),
    .g_out_o   (g_out),
    .din_out_o (din_out),
    .r_in_o    (r_in),
    .a_in_o    (a_in),
    .g_in_o    (g_in),
    .add_sub_o (add_sub),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Output vector layout: ir_in, r_out[7:0], g_out, din_out, r_in[7:0],
  // a_in, g_in, add_sub, done.
  function automatic logic [22:0] pk(input logic i_in, input logic [7:0] ro,
                                     input logic go, input logic dout,
                                     input logic [7:0] ri, input logic ai,
                                     input logic gi, input logic as,
                                     input logic dn);
    return {i_in, ro, go, dout, ri, ai, gi, as, dn};
  endfunction

  function automatic logic [22:0] observed();
    return {ir_in, r_out, g_out, din_out, r_in, a_in, g_in, add_sub, done};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'b1000_0000;
    return v >> idx;
  endfunction

  // Reference behaviour of the control outputs for a given step / IR / Run.
  function automatic logic [22:0] model_out(input int stp, input logic [8:0] ir,
                                            input logic rn);
    logic [2:0] op;
    op = ir[8:6];
    case (stp)
      0: return pk(rn, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
      1: begin
        if (op == 3'd0) return pk(0, oh(ir[2:0]), 0, 0, oh(ir[5:3]), 0, 0, 0, 1);
        if (op == 3'd1) return pk(0, 8'h00, 0, 1, oh(ir[5:3]), 0, 0, 0, 1);
        if (op == 3'd2 || op == 3'd3) return pk(0, oh(ir[5:3]), 0, 0, 8'h00, 1, 0, 0, 0);
        return pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
      end
      2: return pk(0, oh(ir[2:0]), 0, 0, 8'h00, 0, 1, op[0], 0);
      default: return pk(0, 8'h00, 1, 0, oh(ir[5:3]), 0, 0, 0, 1);
    endcase
  endfunction

  task automatic push(input logic [22:0] e, input string tag);
    sb_t s;
    s.exp = e;
    s.tag = tag;
    sb_q.push_back(s);
  endtask

  task automatic pop_check();
    sb_t s;
    logic [22:0] obs;
    s   = sb_q.pop_front();
    obs = observed();
    n_cmp++;
    $display("txn %-14s run=%b din=%03h obs=%06h exp=%06h", s.tag, run, din, obs, s.exp);
    assert (obs === s.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %06h expected %06h", s.tag, obs, s.exp);
    end
  endtask

  task automatic check_invariants();
    int nsrc;
    nsrc = $countones(r_out) + int'(g_out) + int'(din_out);
    n_cmp++;
    assert (nsrc <= 1 && $countones(r_out) <= 1 && $countones(r_in) <= 1) else begin
      n_bad++;
      $error("FAIL onehot_inv: observed r_out=%b g_out=%b din_out=%b r_in=%b expected at most one source and one-hot enables",
             r_out, g_out, din_out, r_in);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the
  // falling edge, return just after the next rising edge.
  task automatic cyc(input logic rn, input logic [8:0] d, input logic [22:0] e,
                     input string tag);
    run = rn;
    din = d;
    push(e, tag);
    @(negedge clk);
    pop_check();
    check_invariants();
    @(posedge clk);
    #1;
  endtask

  logic [22:0] Z;
  int          m_step;
  logic [8:0]  m_ir;
  logic        r_run;
  logic [8:0]  r_din;

  initial begin
    Z   = '0;
    rst = 1'b1;
    run = 1'b0;
    din = '0;

    // Outputs must stay low in reset even with Run high.
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    #1 push(Z, "rst_hold");
    pop_check();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;

    cyc(0, 9'h000, Z, "idle_t0");

    // mvi R2
    cyc(1, 9'b001_010_000, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mvi_t0");
    cyc(0, 9'h1a5,         pk(0, 8'h00, 0, 1, 8'b0010_0000, 0, 0, 0, 1), "mvi_t1");
    cyc(0, 9'h000,         Z, "mvi_back_t0");

    // mv R0,R7
    cyc(1, 9'b000_000_111, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "mv_t0");
    cyc(0, 9'h0ff,         pk(0, 8'b0000_0001, 0, 0, 8'b1000_0000, 0, 0, 0, 1), "mv_t1");

    // add R1,R3
    cyc(1, 9'b010_001_011, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "add_t0");
    cyc(0, 9'h000,         pk(0, 8'b0100_0000, 0, 0, 8'h00, 1, 0, 0, 0), "add_t1");
    cyc(0, 9'h000,         pk(0, 8'b0001_0000, 0, 0, 8'h00, 0, 1, 0, 0), "add_t2");
    cyc(0, 9'h000,         pk(0, 8'h00, 1, 0, 8'b0100_0000, 0, 0, 0, 1), "add_t3");
    cyc(0, 9'h000,         Z, "add_idle");

    // sub R4,R5: Run still high in T1 (ignored), dropped in T2
    cyc(1, 9'b011_100_101, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "sub_t0");
    cyc(1, 9'b001_000_000, pk(0, 8'b0000_1000, 0, 0, 8'h00, 1, 0, 0, 0), "sub_t1");
    cyc(0, 9'h000,         pk(0, 8'b0000_0100, 0, 0, 8'h00, 0, 1, 1, 0), "sub_t2");
    cyc(0, 9'h000,         pk(0, 8'h00, 1, 0, 8'b0000_1000, 0, 0, 0, 1), "sub_t3");
    cyc(0, 9'h000,         Z, "sub_idle");

    // Run held high: back-to-back mvi R5, mv R6,R6, NOP
    cyc(1, 9'b001_101_000, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "bb_mvi_t0");
    cyc(1, 9'b000_001_010, pk(0, 8'h00, 0, 1, 8'b0000_0100, 0, 0, 0, 1), "bb_mvi_t1");
    cyc(1, 9'b000_110_110, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "bb_mv_t0");
    cyc(1, 9'h000,         pk(0, 8'b0000_0010, 0, 0, 8'b0000_0010, 0, 0, 0, 1), "bb_mv_t1");
    cyc(1, 9'b111_011_001, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "nop_t0");
    cyc(1, 9'b000_000_001, pk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1), "nop_t1");
    cyc(0, 9'h000,         Z, "nop_idle");

    // Asynchronous reset in the middle of T2 of add R2,R6
    cyc(1, 9'b010_010_110, pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "arst_add_t0");
    cyc(0, 9'h000,         pk(0, 8'b0010_0000, 0, 0, 8'h00, 1, 0, 0, 0), "arst_add_t1");
    run = 1'b1;
    push(pk(0, 8'b0000_0010, 0, 0, 8'h00, 0, 1, 0, 0), "arst_add_t2");
    pop_check();
    #2 rst = 1'b1;
    #1 push(Z, "arst_now");
    pop_check();
    @(negedge clk);
    push(Z, "arst_held");
    pop_check();
    rst = 1'b0;
    #1 push(pk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0), "arst_rel_run1");
    pop_check();
    run = 1'b0;
    #1 push(Z, "arst_rel_run0");
    pop_check();
    @(posedge clk);
    #1;

    // Random instruction stream against the reference model
    m_step = 0;
    m_ir   = '0;
    for (int i = 0; i < 120; i++) begin
      r_run = ($urandom_range(0, 3) != 0);
      r_din = 9'($urandom_range(0, 511));
      cyc(r_run, r_din, model_out(m_step, m_ir, r_run), "rand");
      case (m_step)
        0: if (r_run) begin
          m_ir   = r_din;
          m_step = 1;
        end
        1: m_step = (m_ir[8:6] == 3'd2 || m_ir[8:6] == 3'd3) ? 2 : 0;
        2: m_step = 3;
        default: m_step = 0;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
